// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB-first across WIDTH cycles.
// Operands are captured on start; {cout,sum} = a + b + cin after WIDTH+1 cycles.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_next;

    full_adder u_fa (
        .A    (r_a_sr[0]),
        .B    (r_b_sr[0]),
        .Cin  (r_carry),
        .Cout (w_cout),
        .S    (w_s)
    );

    // New sum bits enter at the MSB so bit 0 ends up holding the first result bit.
    assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_carry  <= cin;
                        r_sum_sr <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_cout;
                    if (r_cnt == CNT_LAST) begin
                        // Counter parks on the last index; it is cleared on the next acceptance.
                        r_sum   <= w_sum_next;
                        r_cout  <= w_cout;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// Lab 1-bit full-adder cell; the only combinational logic on the per-cycle path.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Cout,
    output logic S
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: an 8-bit instance for directed/back-to-back
// cases and a 4-bit instance swept over every (a,b,cin) combination.
module tb_serial_add_ctrl;

    typedef struct {
        int         due;
        logic [8:0] res;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    exp_t q8[$];
    exp_t q4[$];

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard pops: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            check("sb8_nonempty", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("sum8", 32'(sum8), 32'(e.res[7:0]));
                check("cout8", 32'(cout8), 32'(e.res[8]));
                check("lat8", cyc, e.due);
            end
        end
        if (done4 === 1'b1) begin
            check("sb4_nonempty", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check("sum4", 32'(sum4), 32'(e.res[3:0]));
                check("cout4", 32'(cout4), 32'(e.res[4]));
                check("lat4", cyc, e.due);
            end
        end
    end

    // Called at a negedge with dut8 idle; returns at the negedge before the earliest next accept.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        int s;
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        s = int'(av) + int'(bv) + int'(cv);
        @(posedge clk); #1;
        q8.push_back('{cyc + 8, 9'(s)});
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        repeat (9) @(negedge clk);
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        int s;
        a4 = av; b4 = bv; cin4 = cv; start4 = 1'b1;
        s = int'(av) + int'(bv) + int'(cv);
        @(posedge clk); #1;
        q4.push_back('{cyc + 4, 9'(s)});
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [7:0] ba;
        logic [7:0] bb;
        logic       bc;
        int         s;

        // Reset held two cycles with start asserted: nothing may start.
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h66;
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", 32'(busy8), 32'd0);
            check("rst_done", 32'(done8), 32'd0);
            check("rst_sum", 32'(sum8), 32'h00);
            check("rst_cout", 32'(cout8), 32'd0);
        end
        rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy8), 32'd0);

        // Basic sums and full carry propagation.
        op8(8'h3C, 8'h0F, 1'b0);
        op8(8'h00, 8'h00, 1'b0);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'hA5, 8'h5A, 1'b1);

        // Start while busy: the second request must be ignored.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        q8.push_back('{cyc + 8, 9'h030});
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        check("busy_mid_run", 32'(busy8), 32'd1);
        repeat (6) @(negedge clk);
        check("busy_after_done", 32'(busy8), 32'd0);
        repeat (2) @(negedge clk);
        check("no_second_op", 32'(busy8), 32'd0);
        check("hold_sum", 32'(sum8), 32'h30);

        // Reset mid-operation aborts without a done pulse and clears the result.
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_sum", 32'(sum8), 32'h00);
        check("abort_cout", 32'(cout8), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_still_idle", 32'(busy8), 32'd0);
        op8(8'h01, 8'h01, 1'b0);

        // Back-to-back: start held high, acceptance every WIDTH+2 = 10 cycles.
        start8 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 10; j++) begin
                if (j == 0) begin
                    ba = 8'($urandom); bb = 8'($urandom); bc = 1'($urandom);
                    a8 = ba; b8 = bb; cin8 = bc;
                end else begin
                    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                end
                @(posedge clk); #1;
                if (j == 0) begin
                    s = int'(ba) + int'(bb) + int'(bc);
                    q8.push_back('{cyc + 8, 9'(s)});
                end
                check("b2b_busy", 32'(busy8), 32'(j != 9));
                @(negedge clk);
            end
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=4 exhaustive sweep.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    op4(4'(x), 4'(y), 1'(c));
                end
            end
        end
        repeat (4) @(negedge clk);

        check("sb8_drain", 32'(q8.size()), 32'd0);
        check("sb4_drain", 32'(q4.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
